// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide sequencer.
//   MDU_DATA_W  default operand / HI / LO width
//   MDU_*       op_i encodings (MULT, MULTU, DIV, DIVU)
//   mdu_state_e sequencer state encoding
package mdu_pkg;

    localparam int unsigned MDU_DATA_W = 32;

    localparam logic [1:0] MDU_MULT  = 2'b00;
    localparam logic [1:0] MDU_MULTU = 2'b01;
    localparam logic [1:0] MDU_DIV   = 2'b10;
    localparam logic [1:0] MDU_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDiv,
        StFix
    } mdu_state_e;

endpackage

// File: rtl/mdu_div_step.sv
// mdu_div_step: one combinational restoring-division step.
//   rem_i, quo_i  partial remainder and dividend/quotient shift register
//   div_i         divisor (unsigned magnitude, non-zero)
//   rem_o, quo_o  values after shifting in one dividend bit and a trial subtract
module mdu_div_step #(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0] rem_i,
    input  logic [DATA_W-1:0] quo_i,
    input  logic [DATA_W-1:0] div_i,
    output logic [DATA_W-1:0] rem_o,
    output logic [DATA_W-1:0] quo_o
);

    logic [DATA_W:0] shifted;
    logic [DATA_W:0] diff;

    always_comb begin
        shifted = {rem_i, quo_i[DATA_W-1]};
        // shifted < 2*divisor, so a non-negative difference always fits in DATA_W bits
        // and the top bit of diff is a clean borrow.
        diff    = shifted - {1'b0, div_i};
        if (diff[DATA_W]) begin
            rem_o = shifted[DATA_W-1:0];
            quo_o = {quo_i[DATA_W-2:0], 1'b0};
        end else begin
            rem_o = diff[DATA_W-1:0];
            quo_o = {quo_i[DATA_W-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/mdu_seq.sv
// mdu_seq: MIPS multiply/divide sequencer owning the HI/LO registers.
//   start_i/op_i/a_i/b_i  launch MULT/MULTU/DIV/DIVU from EX
//   flush_i               abort the in-flight op (HI/LO untouched)
//   hilo_rd_i             MFHI/MFLO in ID (stall source)
//   hi_we_i/lo_we_i/wdata_i  MTHI/MTLO, honoured only when idle
//   busy_o, done_o        op in flight / one-cycle completion pulse
//   stall_o               combinational stall to hazard logic
//   hi_o, lo_o            registered HI/LO
// Optional build macro MDU_DIV0_FLAG_EN adds div0_o, pulsing with done_o when a
// divide by zero completes.
module mdu_seq
    import mdu_pkg::*;
#(
    parameter int unsigned DATA_W  = MDU_DATA_W,
    parameter int unsigned MUL_LAT = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [1:0]        op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              flush_i,
    input  logic              hilo_rd_i,
    input  logic              hi_we_i,
    input  logic              lo_we_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              stall_o,
`ifdef MDU_DIV0_FLAG_EN
    output logic              div0_o,
`endif
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    localparam int unsigned CntMax = (MUL_LAT > DATA_W) ? MUL_LAT : DATA_W;
    localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

    mdu_state_e          state_q;
    logic [CntW-1:0]     cnt_q;
    logic [1:0]          op_q;
    logic [DATA_W-1:0]   a_q, b_q;
    logic [DATA_W-1:0]   rem_q, quo_q;
    logic [DATA_W-1:0]   hi_q, lo_q;
    logic                done_q;
    logic                div0_q;

    logic [DATA_W-1:0]   a_mag_in;
    logic [DATA_W-1:0]   divisor;
    logic [DATA_W-1:0]   rem_nxt, quo_nxt;
    logic [2*DATA_W-1:0] a_ext, b_ext, product;
    logic                is_div_s;
    logic [DATA_W-1:0]   quo_fix, rem_fix;

    always_comb begin
        // Only DIV works on magnitudes; DIVU divides raw values.
        a_mag_in = (op_i == MDU_DIV && a_i[DATA_W-1]) ? (~a_i + 1'b1) : a_i;
        is_div_s = (op_q == MDU_DIV);
        divisor  = (is_div_s && b_q[DATA_W-1]) ? (~b_q + 1'b1) : b_q;

        // Low 2W bits of a sign/zero-extended product equal the signed/unsigned result.
        a_ext    = {{DATA_W{(op_q == MDU_MULT) & a_q[DATA_W-1]}}, a_q};
        b_ext    = {{DATA_W{(op_q == MDU_MULT) & b_q[DATA_W-1]}}, b_q};
        product  = a_ext * b_ext;

        // 0x80000000 / -1 falls out naturally: the negated magnitude wraps back.
        quo_fix  = (is_div_s && (a_q[DATA_W-1] ^ b_q[DATA_W-1])) ? (~quo_q + 1'b1) : quo_q;
        rem_fix  = (is_div_s && a_q[DATA_W-1]) ? (~rem_q + 1'b1) : rem_q;
    end

    mdu_div_step #(
        .DATA_W (DATA_W)
    ) u_div_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .div_i (divisor),
        .rem_o (rem_nxt),
        .quo_o (quo_nxt)
    );

`ifdef MDU_DIV0_FLAG_EN
    logic div0_out_q;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_q    <= MDU_MULT;
            a_q     <= '0;
            b_q     <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            div0_q  <= 1'b0;
`ifdef MDU_DIV0_FLAG_EN
            div0_out_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
`ifdef MDU_DIV0_FLAG_EN
            div0_out_q <= 1'b0;
`endif
            case (state_q)
                StIdle: begin
                    if (hi_we_i) hi_q <= wdata_i;
                    if (lo_we_i) lo_q <= wdata_i;
                    if (start_i && !flush_i) begin
                        op_q  <= op_i;
                        a_q   <= a_i;
                        b_q   <= b_i;
                        rem_q <= '0;
                        quo_q <= a_mag_in;
                        if (!op_i[1]) begin
                            state_q <= StMul;
                            cnt_q   <= CntW'(MUL_LAT - 1);
                            div0_q  <= 1'b0;
                        end else if (b_i == '0) begin
                            state_q <= StFix;
                            div0_q  <= 1'b1;
                        end else begin
                            state_q <= StDiv;
                            cnt_q   <= CntW'(DATA_W - 1);
                            div0_q  <= 1'b0;
                        end
                    end
                end
                StMul: begin
                    if (flush_i) begin
                        state_q <= StIdle;
                    end else if (cnt_q == '0) begin
                        {hi_q, lo_q} <= product;
                        done_q       <= 1'b1;
                        state_q      <= StIdle;
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                StDiv: begin
                    if (flush_i) begin
                        state_q <= StIdle;
                    end else begin
                        rem_q <= rem_nxt;
                        quo_q <= quo_nxt;
                        if (cnt_q == '0) state_q <= StFix;
                        else             cnt_q   <= cnt_q - CntW'(1);
                    end
                end
                StFix: begin
                    if (!flush_i) begin
                        if (div0_q) begin
                            lo_q <= '1;
                            hi_q <= a_q;
                        end else begin
                            lo_q <= quo_fix;
                            hi_q <= rem_fix;
                        end
                        done_q <= 1'b1;
`ifdef MDU_DIV0_FLAG_EN
                        div0_out_q <= div0_q;
`endif
                    end
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy_o  = (state_q != StIdle);
    assign done_o  = done_q;
    assign stall_o = busy_o & (hilo_rd_i | hi_we_i | lo_we_i | start_i);
    assign hi_o    = hi_q;
    assign lo_o    = lo_q;
`ifdef MDU_DIV0_FLAG_EN
    assign div0_o  = div0_out_q;
`endif

endmodule

// File: tb/tb_mdu_seq.sv
module tb_mdu_seq;
    import mdu_pkg::*;

    localparam int MUL_LAT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op_s = 2'b00;
    logic [31:0] a_s = '0, b_s = '0;
    logic        flush = 1'b0;
    logic        hilo_rd = 1'b0;
    logic        hi_we = 1'b0, lo_we = 1'b0;
    logic [31:0] wdata = '0;
    logic        busy, done, stall;
    logic [31:0] hi, lo;
`ifdef MDU_DIV0_FLAG_EN
    logic        div0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mdu_seq #(
        .DATA_W  (32),
        .MUL_LAT (MUL_LAT)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .start_i   (start),
        .op_i      (op_s),
        .a_i       (a_s),
        .b_i       (b_s),
        .flush_i   (flush),
        .hilo_rd_i (hilo_rd),
        .hi_we_i   (hi_we),
        .lo_we_i   (lo_we),
        .wdata_i   (wdata),
        .busy_o    (busy),
        .done_o    (done),
        .stall_o   (stall),
`ifdef MDU_DIV0_FLAG_EN
        .div0_o    (div0),
`endif
        .hi_o      (hi),
        .lo_o      (lo)
    );

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic from the architectural rules.
    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] ehi, output logic [31:0] elo,
                                  output int lat);
        longint          sp;
        longint unsigned up;
        int              sa, sb;
        sa = a;
        sb = b;
        ehi = '0;
        elo = '0;
        lat = MUL_LAT;
        case (op)
            MDU_MULT: begin
                sp  = longint'(sa) * longint'(sb);
                ehi = sp[63:32];
                elo = sp[31:0];
            end
            MDU_MULTU: begin
                up  = {32'd0, a} * {32'd0, b};
                ehi = up[63:32];
                elo = up[31:0];
            end
            default: begin
                lat = (b == 32'd0) ? 1 : 33;
                if (b == 32'd0) begin
                    elo = 32'hffff_ffff;
                    ehi = a;
                end else if (op == MDU_DIVU) begin
                    elo = a / b;
                    ehi = a % b;
                end else if (a == 32'h8000_0000 && b == 32'hffff_ffff) begin
                    elo = 32'h8000_0000;
                    ehi = 32'd0;
                end else begin
                    elo = sa / sb;
                    ehi = sa % sb;
                end
            end
        endcase
    endfunction

    task automatic do_op(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                         input int elat);
        int nb;
        @(negedge clk);
        start = 1'b1; op_s = op; a_s = a; b_s = b;
        @(negedge clk);
        start = 1'b0;
        nb = 0;
        while (busy === 1'b1 && nb < 200) begin
            nb++;
            @(negedge clk);
        end
        check({name, " busy cycles"}, 64'(nb), 64'(elat));
        check({name, " done"}, 64'(done), 64'd1);
        check({name, " hi"}, 64'(hi), 64'(ehi));
        check({name, " lo"}, 64'(lo), 64'(elo));
`ifdef MDU_DIV0_FLAG_EN
        check({name, " div0"}, 64'(div0), 64'(op[1] && b == 32'd0));
`endif
    endtask

    initial begin
        vec_t        vecs[9];
        logic [31:0] ehi, elo, ra, rb;
        logic [1:0]  rop;
        int          lat, nb;
        bit          done_seen;

        vecs[0] = '{"mult -3*7",   MDU_MULT,  32'hffff_fffd, 32'd7, 32'hffff_ffff, 32'hffff_ffeb, 4};
        vecs[1] = '{"divu 100/7",  MDU_DIVU,  32'd100, 32'd7, 32'd2, 32'd14, 33};
        vecs[2] = '{"div -7/2",    MDU_DIV,   32'hffff_fff9, 32'd2, 32'hffff_ffff, 32'hffff_fffd, 33};
        vecs[3] = '{"div min/-1",  MDU_DIV,   32'h8000_0000, 32'hffff_ffff, 32'd0, 32'h8000_0000, 33};
        vecs[4] = '{"divu 5/0",    MDU_DIVU,  32'd5, 32'd0, 32'd5, 32'hffff_ffff, 1};
        vecs[5] = '{"div -5/0",    MDU_DIV,   32'hffff_fffb, 32'd0, 32'hffff_fffb, 32'hffff_ffff, 1};
        vecs[6] = '{"multu max^2", MDU_MULTU, 32'hffff_ffff, 32'hffff_ffff, 32'hffff_fffe, 32'd1, 4};
        vecs[7] = '{"div 7/-2",    MDU_DIV,   32'd7, 32'hffff_fffe, 32'd1, 32'hffff_fffd, 33};
        vecs[8] = '{"divu max/1",  MDU_DIVU,  32'hffff_ffff, 32'd1, 32'd0, 32'hffff_ffff, 33};

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset stall", 64'(stall), 64'd0);
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);

        foreach (vecs[i])
            do_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo,
                  vecs[i].lat);

        // MTHI / MTLO preset, visible the cycle after the write
        @(negedge clk);
        hi_we = 1'b1; wdata = 32'h11;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h22;
        check("mthi", 64'(hi), 64'h11);
        @(negedge clk);
        lo_we = 1'b0;
        check("mtlo", 64'(lo), 64'h22);

        // Flush at busy cycle 10 of a DIVU
        start = 1'b1; op_s = MDU_DIVU; a_s = 32'd9; b_s = 32'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("flush pre busy", 64'(busy), 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush busy", 64'(busy), 64'd0);
        check("flush done", 64'(done), 64'd0);
        check("flush hi", 64'(hi), 64'h11);
        check("flush lo", 64'(lo), 64'h22);
        @(negedge clk);
        check("flush no late done", 64'(done), 64'd0);

        // MULT with MFHI pending: stall every busy cycle, MTHI while busy ignored
        start = 1'b1; op_s = MDU_MULT; a_s = 32'd2; b_s = 32'd3; hilo_rd = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1 check("stall c1", 64'(stall), 64'd1);
        @(negedge clk);
        hi_we = 1'b1; wdata = 32'hdead;
        #1 check("stall c2", 64'(stall), 64'd1);
        @(negedge clk);
        hi_we = 1'b0;
        #1 check("stall c3", 64'(stall), 64'd1);
        check("mthi while busy", 64'(hi), 64'h11);
        @(negedge clk);
        #1 check("stall c4", 64'(stall), 64'd1);
        @(negedge clk);
        #1 check("stall done cycle", 64'(stall), 64'd0);
        check("mult done", 64'(done), 64'd1);
        check("mult hi", 64'(hi), 64'd0);
        check("mult lo", 64'(lo), 64'd6);
        hilo_rd = 1'b0;

        // Start in the done cycle, together with MTLO: both honoured
        start = 1'b1; op_s = MDU_DIVU; a_s = 32'd7; b_s = 32'd0;
        lo_we = 1'b1; wdata = 32'h55;
        @(negedge clk);
        start = 1'b0; lo_we = 1'b0;
        check("start in done cycle", 64'(busy), 64'd1);
        check("mtlo with start", 64'(lo), 64'h55);
        @(negedge clk);
        check("div0 done", 64'(done), 64'd1);
        check("div0 lo", 64'(lo), 64'hffff_ffff);
        check("div0 hi", 64'(hi), 64'd7);

        // start_i while busy is ignored (and stalls)
        @(negedge clk);
        start = 1'b1; op_s = MDU_DIV; a_s = 32'hffff_ffec; b_s = 32'd3;
        @(negedge clk);
        start = 1'b1; op_s = MDU_MULTU; a_s = 32'd9; b_s = 32'd9;
        #1 check("stall on start", 64'(stall), 64'd1);
        nb = 1;
        @(negedge clk);
        start = 1'b0;
        while (busy === 1'b1 && nb < 200) begin
            nb++;
            @(negedge clk);
        end
        check("busy start latency", 64'(nb), 64'd33);
        check("busy start lo", 64'(lo), 64'hffff_fffa);
        check("busy start hi", 64'(hi), 64'hffff_fffe);

        // Flush together with start in IDLE drops the start
        start = 1'b1; flush = 1'b1; op_s = MDU_MULT; a_s = 32'd4; b_s = 32'd4;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("flush+start", 64'(busy), 64'd0);

        // Reset mid-operation clears HI/LO and kills the op
        start = 1'b1; op_s = MDU_MULTU; a_s = 32'd5; b_s = 32'd5;
        @(negedge clk);
        start = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst busy", 64'(busy), 64'd0);
        check("midrst hi", 64'(hi), 64'd0);
        check("midrst lo", 64'(lo), 64'd0);
        done_seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (done) done_seen = 1'b1;
        end
        check("midrst no done", 64'(done_seen), 64'd0);

        // Randomised ops against the reference model
        for (int k = 0; k < 40; k++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 15);
                2:       rb = 32'hffff_ffff;
                default: rb = $urandom;
            endcase
            model(rop, ra, rb, ehi, elo, lat);
            do_op($sformatf("rand%0d op%0d", k, rop), rop, ra, rb, ehi, elo, lat);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
